// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/halt/step execution controller.
package run_ctrl_pkg;

    // State encoding is visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } run_state_t;

    // A step request with a count of zero still advances the core one cycle.
    localparam bit STEP_ZERO_AS_ONE = 1'b1;

endpackage

// File: rtl/run_ctrl_edge_detect.sv
// Registered rising-edge detector: the request is captured once, then compared
// with its previous captured value, so a held level yields exactly one pulse.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic pulse
);

    logic req_r;
    logic req_p;

    // Capture the request and its one-cycle-delayed copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_r <= 1'b0;
            req_p <= 1'b0;
        end else begin
            req_r <= req;
            req_p <= req_r;
        end
    end

    // Pulse is high in the cycle after the request was first captured high.
    always_comb begin
        pulse = req_r & ~req_p;
    end

endmodule

// File: rtl/run_ctrl.sv
// Execution controller: gates the core enable for free-run, halt, counted
// stepping and PC breakpoints, and counts cycles in which the core advanced.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_ADDR_WIDTH = 4,
    parameter int unsigned STEP_CNT_WIDTH   = 8,
    parameter int unsigned RETIRE_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run_req,
    input  logic                        halt_req,
    input  logic                        step_req,
    input  logic [STEP_CNT_WIDTH-1:0]   step_count,
    input  logic                        bp_en,
    input  logic [INSTR_ADDR_WIDTH-1:0] bp_addr,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc_count,
    output logic                        core_en,
    output logic [1:0]                  state,
    output logic                        bp_hit,
    output logic [RETIRE_WIDTH-1:0]     retired
);

    run_state_t                  state_q, state_d;
    logic [STEP_CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [STEP_CNT_WIDTH-1:0]   step_load;
    logic [INSTR_ADDR_WIDTH-1:0] resume_pc_q;
    logic                        skip_q;
    logic                        bp_hit_q;
    logic [RETIRE_WIDTH-1:0]     retired_q;
    logic                        run_ev, halt_ev, step_ev;
    logic                        active;
    logic                        bp_match;
    logic                        leaving_stop;

    edge_detect u_run_edge (
        .clk   (clk),
        .reset (reset),
        .req   (run_req),
        .pulse (run_ev)
    );

    edge_detect u_halt_edge (
        .clk   (clk),
        .reset (reset),
        .req   (halt_req),
        .pulse (halt_ev)
    );

    edge_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .req   (step_req),
        .pulse (step_ev)
    );

    // Breakpoint compare and core enable; the instruction at bp_addr is held
    // off on the matching cycle unless we have just resumed from that PC.
    always_comb begin
        active   = (state_q == RUN) || (state_q == STEP);
        bp_match = active & bp_en & (pc_count == bp_addr) & ~skip_q;
        core_en  = active & ~bp_match;
        step_load = (STEP_ZERO_AS_ONE && (step_count == '0)) ?
                    STEP_CNT_WIDTH'(1) : step_count;
    end

    // Next-state and step-counter update; halt beats step beats run.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            HALT, BREAK: begin
                if (halt_ev) begin
                    state_d = state_q;
                end else if (step_ev) begin
                    state_d     = STEP;
                    remaining_d = step_load;
                end else if (run_ev) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_ev) begin
                    state_d = HALT;
                end else if (bp_match) begin
                    state_d = BREAK;
                end
            end
            STEP: begin
                if (halt_ev) begin
                    state_d     = HALT;
                    remaining_d = '0;
                end else if (bp_match) begin
                    state_d     = BREAK;
                    remaining_d = '0;
                end else if (core_en) begin
                    if (remaining_q == STEP_CNT_WIDTH'(1)) begin
                        state_d     = HALT;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - STEP_CNT_WIDTH'(1);
                    end
                end
            end
        endcase
        leaving_stop = ((state_q == HALT) || (state_q == BREAK)) && (state_d != state_q);
    end

    // State, step counter, breakpoint-skip tracking, hit pulse and retire count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HALT;
            remaining_q <= '0;
            resume_pc_q <= '0;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bp_hit_q    <= (state_d == BREAK) && (state_q != BREAK);
            if (core_en) begin
                retired_q <= retired_q + RETIRE_WIDTH'(1);
            end
            // Resuming arms the skip so the breakpoint PC can execute once,
            // even if the core stalls on it for several cycles.
            if (leaving_stop) begin
                resume_pc_q <= pc_count;
                skip_q      <= 1'b1;
            end else if (skip_q && (pc_count != resume_pc_q)) begin
                skip_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state   = state_q;
        bp_hit  = bp_hit_q;
        retired = retired_q;
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios followed by random
// request traffic, all compared against a cycle-level behavioural model.
module tb_run_ctrl;

    localparam int AW = 4;
    localparam int SW = 8;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run_req = 1'b0;
    logic          halt_req = 1'b0;
    logic          step_req = 1'b0;
    logic [SW-1:0] step_count = '0;
    logic          bp_en = 1'b0;
    logic [AW-1:0] bp_addr = '0;
    logic [AW-1:0] pc_count = '0;
    logic          core_en;
    logic [1:0]    state;
    logic          bp_hit;
    logic [RW-1:0] retired;

    run_ctrl #(
        .INSTR_ADDR_WIDTH (AW),
        .STEP_CNT_WIDTH   (SW),
        .RETIRE_WIDTH     (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .step_count (step_count),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_count   (pc_count),
        .core_en    (core_en),
        .state      (state),
        .bp_hit     (bp_hit),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: mode 0 halted, 1 running, 2 stepping, 3 stopped at bp.
    int m_mode, m_left, m_ret, m_rpc;
    bit m_bphit, m_skip, exp_en, freeze;
    // Request levels as seen at the last two clock edges: [halt, step, run][age].
    bit seen [3][2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_ret = 0; m_rpc = 0;
        m_bphit = 0; m_skip = 0; exp_en = 0;
        for (int i = 0; i < 3; i++) begin
            seen[i][0] = 0;
            seen[i][1] = 0;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model over the
    // rising edge, then let the pretend core move its PC if it was enabled.
    task automatic tick();
        bit ev_h, ev_s, ev_r, active, hit;
        int nxt;
        @(negedge clk);
        if (reset) begin
            model_reset();
            check("rst_core_en", core_en, 0);
            check("rst_state", state, 0);
            check("rst_bp_hit", bp_hit, 0);
            check("rst_retired", retired, 0);
        end else begin
            ev_h   = seen[0][0] && !seen[0][1];
            ev_s   = seen[1][0] && !seen[1][1];
            ev_r   = seen[2][0] && !seen[2][1];
            active = (m_mode == 1) || (m_mode == 2);
            hit    = active && bp_en && (pc_count == bp_addr) && !m_skip;
            exp_en = active && !hit;
            check("core_en", core_en, exp_en);
            check("state", state, m_mode);
            check("bp_hit", bp_hit, m_bphit);
            check("retired", retired, m_ret);
            nxt = m_mode;
            if (m_mode == 0 || m_mode == 3) begin
                if (!ev_h && ev_s) begin
                    nxt = 2;
                    m_left = (step_count == 0) ? 1 : int'(step_count);
                end else if (!ev_h && ev_r) begin
                    nxt = 1;
                end
            end else if (m_mode == 1) begin
                if (ev_h) nxt = 0;
                else if (hit) nxt = 3;
            end else begin
                if (ev_h || hit) begin
                    nxt = ev_h ? 0 : 3;
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) nxt = 0;
                end
            end
            m_ret = (m_ret + int'(exp_en)) % 65536;
            if ((m_mode == 0 || m_mode == 3) && nxt != m_mode) begin
                m_skip = 1;
                m_rpc  = int'(pc_count);
            end else if (m_skip && int'(pc_count) != m_rpc) begin
                m_skip = 0;
            end
            m_bphit = (nxt == 3) && (m_mode != 3);
            m_mode  = nxt;
            for (int i = 0; i < 3; i++) seen[i][1] = seen[i][0];
            seen[0][0] = halt_req;
            seen[1][0] = step_req;
            seen[2][0] = run_req;
        end
        @(posedge clk);
        #1;
        if (exp_en && !freeze) pc_count = pc_count + 1'b1;
    endtask

    // which: 0 halt, 1 step, 2 run; request held high for one cycle.
    task automatic req_pulse(input int which);
        if (which == 0) halt_req = 1'b1;
        if (which == 1) step_req = 1'b1;
        if (which == 2) run_req = 1'b1;
        tick();
        halt_req = 1'b0;
        step_req = 1'b0;
        run_req  = 1'b0;
    endtask

    initial begin
        model_reset();
        freeze = 0;
        // Reset held for a few cycles.
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Free run for a while, then halt.
        req_pulse(2);
        repeat (12) tick();
        req_pulse(0);
        repeat (3) tick();

        // Counted steps: 3, then 0 treated as 1.
        step_count = 8'd3;
        req_pulse(1);
        repeat (7) tick();
        step_count = 8'd0;
        req_pulse(1);
        repeat (5) tick();

        // Breakpoint at 5 from PC 0, then resume past it and wrap back.
        pc_count = 4'd0;
        bp_en    = 1'b1;
        bp_addr  = 4'd5;
        req_pulse(2);
        repeat (10) tick();
        req_pulse(2);
        repeat (22) tick();

        // Coincident requests: halt wins over run, step wins over run.
        req_pulse(0);
        repeat (3) tick();
        bp_en    = 1'b0;
        run_req  = 1'b1;
        halt_req = 1'b1;
        tick();
        run_req  = 1'b0;
        halt_req = 1'b0;
        repeat (4) tick();
        step_count = 8'd2;
        run_req  = 1'b1;
        step_req = 1'b1;
        tick();
        run_req  = 1'b0;
        step_req = 1'b0;
        repeat (6) tick();

        // Asynchronous reset in the middle of a long step.
        step_count = 8'd10;
        req_pulse(1);
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_core_en", core_en, 0);
        check("async_retired", retired, 0);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();

        // Wait-stall on the breakpoint PC after resuming.
        pc_count = 4'd2;
        bp_en    = 1'b1;
        bp_addr  = 4'd5;
        req_pulse(2);
        repeat (6) tick();
        freeze = 1;
        req_pulse(2);
        repeat (6) tick();
        freeze = 0;
        repeat (4) tick();
        req_pulse(0);
        repeat (2) tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) run_req = ~run_req;
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 5) == 0) step_req = ~step_req;
            if ($urandom_range(0, 3) == 0) step_count = SW'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 29) == 0) bp_addr = AW'($urandom_range(0, 15));
            freeze = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
